mio_bus_arbiter: RTL and testbench

Two-requester memory/IO bus arbiter for the multi-cycle CPU. It shares the single memory port and the peripheral bus between the CPU controller and an auxiliary master (DMA/VGA fetch), and generates the `MIO_ready` handshake that releases the CPU from its fetch and memory states. Addresses are decoded into RAM or IO regions. Each transaction runs through a small FSM with fixed RAM latency and a bounded IO wait.

---
 rtl/mio_pkg.sv | 20 ++
 rtl/mio_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mio_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_pkg.sv
// mio_bus_arbiter shared definitions.
// State and owner encodings plus region/error constants.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    IO_ACC  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_t;

  localparam logic [3:0]  IO_BASE_DEF = 4'hF;
  localparam logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mio_bus_arbiter.sv
// Two-master memory/IO arbiter with round-robin grant,
// fixed RAM latency and bounded IO wait.
module mio_bus_arbiter
  import mio_pkg::*;
#(
  parameter int         RAM_LAT    = 2,
  parameter int         IO_TIMEOUT = 16,
  parameter logic [3:0] IO_BASE    = IO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        MIO_ready,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic [31:0] aux_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ready,
  output logic        bus_err,
  output logic        err_sticky
);

  localparam logic [7:0] RAM_LAST = 8'(RAM_LAT - 1);
  localparam logic [7:0] IO_LAST  = 8'(IO_TIMEOUT - 1);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  owner_t      last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] cpu_rd_q, cpu_rd_d;
  logic [31:0] aux_rd_q, aux_rd_d;
  logic        err_pend_q, err_pend_d;
  logic        sticky_q, sticky_d;

  owner_t      pick;
  logic        cap;
  logic [31:0] cap_val;

  // Next-state: grant, access sequencing and read capture
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    cpu_rd_d   = cpu_rd_q;
    aux_rd_d   = aux_rd_q;
    err_pend_d = err_pend_q;
    sticky_d   = sticky_q;
    pick       = OWN_CPU;
    cap        = 1'b0;
    cap_val    = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && aux_req) begin
          pick = (last_q == OWN_CPU) ? OWN_AUX : OWN_CPU;
        end else if (aux_req) begin
          pick = OWN_AUX;
        end
        if (cpu_req || aux_req) begin
          owner_d = pick;
          last_d  = pick;
          if (pick == OWN_AUX) begin
            we_d    = aux_we;
            addr_d  = aux_addr;
            wdata_d = aux_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          if (addr_d[31:28] == IO_BASE) begin
            state_d = IO_ACC;
            cnt_d   = '0;
          end else begin
            state_d = RAM_ACC;
            cnt_d   = RAM_LAST;
          end
        end
      end
      RAM_ACC: begin
        if (cnt_q == '0) begin
          cap     = ~we_q;
          cap_val = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      IO_ACC: begin
        if (io_ready) begin
          cap     = ~we_q;
          cap_val = io_rdata;
          state_d = DONE;
        end else if (cnt_q == IO_LAST) begin
          cap        = ~we_q;
          cap_val    = ERR_RDATA;
          err_pend_d = 1'b1;
          sticky_d   = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        err_pend_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cap) begin
      if (owner_q == OWN_AUX) aux_rd_d = cap_val;
      else                    cpu_rd_d = cap_val;
    end
  end

  // State and latch registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_CPU;
      last_q     <= OWN_AUX;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      cpu_rd_q   <= '0;
      aux_rd_q   <= '0;
      err_pend_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      cpu_rd_q   <= cpu_rd_d;
      aux_rd_q   <= aux_rd_d;
      err_pend_q <= err_pend_d;
      sticky_q   <= sticky_d;
    end
  end

  assign mem_en     = (state_q == RAM_ACC);
  assign mem_we     = mem_en & we_q & (cnt_q == RAM_LAST);
  assign mem_addr   = mem_en ? addr_q  : '0;
  assign mem_wdata  = mem_en ? wdata_q : '0;
  assign io_en      = (state_q == IO_ACC);
  assign io_we      = io_en & we_q & (cnt_q == '0);
  assign io_addr    = io_en ? addr_q  : '0;
  assign io_wdata   = io_en ? wdata_q : '0;
  assign MIO_ready  = (state_q == DONE) & (owner_q == OWN_CPU);
  assign aux_ready  = (state_q == DONE) & (owner_q == OWN_AUX);
  assign bus_err    = (state_q == DONE) & err_pend_q;
  assign err_sticky = sticky_q;
  assign cpu_rdata  = cpu_rd_q;
  assign aux_rdata  = aux_rd_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Self-checking bench for mio_bus_arbiter.
// Transaction-level reference model with randomized traffic.
module tb_mio_bus_arbiter;

  localparam int RL = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        MIO_ready, aux_ready;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        mem_en, mem_we, io_en, io_we, io_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        bus_err, err_sticky;

  logic [31:0] ram_data = '0;
  logic [31:0] io_data  = '0;
  int          io_delay = 0;
  int          io_cnt   = 0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cpu_rd, m_aux_rd;
  bit          m_sticky;
  bit          m_last;

  mio_bus_arbiter #(
    .RAM_LAT(RL), .IO_TIMEOUT(TO), .IO_BASE(4'hF)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .MIO_ready(MIO_ready), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_rdata(aux_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_en(io_en), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready),
    .bus_err(bus_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  assign mem_rdata = ram_data;
  assign io_rdata  = io_data;

  // IO device: answers in its io_delay-th enabled cycle, 0 = never
  always @(posedge clk) io_cnt <= io_en ? io_cnt + 1 : 0;
  assign io_ready = io_en && (io_delay > 0) && (io_cnt == io_delay - 1);

  task automatic reset_model();
    m_cpu_rd = '0;
    m_aux_rd = '0;
    m_sticky = 1'b0;
    m_last   = 1'b1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    io_delay = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({MIO_ready, aux_ready, mem_en, mem_we, io_en, io_we,
         bus_err, err_sticky} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000",
        {MIO_ready, aux_ready, mem_en, mem_we, io_en, io_we,
         bus_err, err_sticky});
    end
    checks++;
    if (cpu_rdata !== 32'h0 || aux_rdata !== 32'h0 ||
        mem_addr !== 32'h0 || io_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want zeros",
        cpu_rdata, aux_rdata, mem_addr, io_addr);
    end
    reset = 1'b0;
    reset_model();
    @(negedge clk);
  endtask

  // Single access; caller is at a negedge with the DUT idle
  task automatic run_one(input bit aux, input bit we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input int dly, input string nm);
    bit          is_io, exp_err, got, wrong, bad_bus;
    int          lat, n, men, mwe, iwe;
    logic [31:0] exp_rd;
    is_io = (addr[31:28] == 4'hF);
    ram_data = rd;
    io_data  = rd;
    io_delay = dly;
    if (!is_io) begin
      lat = RL + 1; exp_err = 0; exp_rd = rd;
    end else if (dly >= 1 && dly <= TO) begin
      lat = dly + 1; exp_err = 0; exp_rd = rd;
    end else begin
      lat = TO + 1; exp_err = 1; exp_rd = 32'hFFFF_FFFF;
    end
    if (aux) begin
      aux_req = 1; aux_we = we; aux_addr = addr; aux_wdata = wd;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    n = 0; got = 0; wrong = 0; bad_bus = 0;
    men = 0; mwe = 0; iwe = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (aux) begin aux_addr = ~addr; aux_wdata = ~wd; aux_we = ~we; end
        else begin cpu_addr = ~addr; cpu_wdata = ~wd; cpu_we = ~we; end
      end
      men += int'(mem_en);
      mwe += int'(mem_we);
      iwe += int'(io_we);
      if (mem_en && (mem_addr !== addr || mem_wdata !== wd)) bad_bus = 1;
      if (io_en && (io_addr !== addr || io_wdata !== wd)) bad_bus = 1;
      if (aux ? aux_ready : MIO_ready) got = 1;
      if (aux ? MIO_ready : aux_ready) wrong = 1;
    end
    if (!we) begin
      if (aux) m_aux_rd = exp_rd;
      else     m_cpu_rd = exp_rd;
    end
    if (exp_err) m_sticky = 1'b1;
    m_last = aux;
    checks++;
    if (!got || n != lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", nm, n, lat);
    end
    checks++;
    if (wrong) begin
      errors++;
      $display("FAIL %s other_ready got 1 want 0", nm);
    end
    checks++;
    if (cpu_rdata !== m_cpu_rd || aux_rdata !== m_aux_rd) begin
      errors++;
      $display("FAIL %s rdata got %h/%h want %h/%h", nm,
        cpu_rdata, aux_rdata, m_cpu_rd, m_aux_rd);
    end
    checks++;
    if (bus_err !== exp_err || err_sticky !== m_sticky) begin
      errors++;
      $display("FAIL %s err got %b/%b want %b/%b", nm,
        bus_err, err_sticky, exp_err, m_sticky);
    end
    checks++;
    if (men != (is_io ? 0 : RL) || mwe != int'(!is_io && we) ||
        iwe != int'(is_io && we)) begin
      errors++;
      $display("FAIL %s strobes got %0d/%0d/%0d want %0d/%0d/%0d",
        nm, men, mwe, iwe, is_io ? 0 : RL,
        int'(!is_io && we), int'(is_io && we));
    end
    checks++;
    if (bad_bus) begin
      errors++;
      $display("FAIL %s bus_addr_data got changed want latched", nm);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (MIO_ready !== 0 || aux_ready !== 0 || bus_err !== 0 ||
        cpu_rdata !== m_cpu_rd || aux_rdata !== m_aux_rd) begin
      errors++;
      $display("FAIL %s after_pulse got %b%b%b %h %h want 000 %h %h",
        nm, MIO_ready, aux_ready, bus_err, cpu_rdata, aux_rdata,
        m_cpu_rd, m_aux_rd);
    end
  endtask

  task automatic test_ram_read();
    run_one(0, 0, 32'h0000_0010, 32'h0, 32'h1234_5678, 0, "ram_read");
  endtask

  task automatic test_round_robin();
    bit winner, exp_w, got;
    int cnt;
    test_reset();
    ram_data = 32'hCAFE_0001;
    cpu_req = 1; cpu_addr = 32'h0000_0100;
    aux_req = 1; aux_addr = 32'h0000_0200;
    for (int k = 0; k < 5; k++) begin
      exp_w = ~m_last;
      cnt = 0; got = 0;
      while (!got && cnt < 50) begin
        @(negedge clk);
        cnt++;
        if (MIO_ready || aux_ready) got = 1;
      end
      winner = aux_ready;
      checks++;
      if (!got || winner != exp_w || (MIO_ready && aux_ready)) begin
        errors++;
        $display("FAIL rr_grant%0d got %b%b want owner %0d",
          k, MIO_ready, aux_ready, exp_w);
      end
      checks++;
      if (cnt != ((k == 0) ? RL + 1 : RL + 2)) begin
        errors++;
        $display("FAIL rr_spacing%0d got %0d want %0d",
          k, cnt, (k == 0) ? RL + 1 : RL + 2);
      end
      m_last = exp_w;
      if (exp_w) m_aux_rd = ram_data;
      else       m_cpu_rd = ram_data;
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (cpu_rdata !== m_cpu_rd || aux_rdata !== m_aux_rd) begin
      errors++;
      $display("FAIL rr_rdata got %h %h want %h %h",
        cpu_rdata, aux_rdata, m_cpu_rd, m_aux_rd);
    end
  endtask

  task automatic test_io_write();
    run_one(1, 1, 32'hF000_0004, 32'h0000_00A5, 32'h0, 3, "io_write");
  endtask

  task automatic test_io_timeout();
    run_one(0, 0, 32'hF000_0000, 32'h0, 32'h1111_2222, 0, "io_timeout");
    run_one(1, 0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0, "sticky_ram");
    run_one(0, 0, 32'hF000_0008, 32'h0, 32'h3333_4444, 5, "sticky_io");
  endtask

  task automatic test_io_edge();
    run_one(0, 0, 32'hF000_000C, 32'h0, 32'h5555_AAAA, TO, "io_edge");
  endtask

  task automatic test_reset_mid();
    test_reset();
    ram_data = 32'h7777_8888;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0020;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_en !== 0 || mem_addr !== 32'h0 || MIO_ready !== 0 ||
        cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got %b %h %b %h want 0 0 0 0",
        mem_en, mem_addr, MIO_ready, cpu_rdata);
    end
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    run_one(0, 0, 32'h0000_0020, 32'h0, 32'h7777_8888, 0, "after_reset");
  endtask

  task automatic test_random();
    bit          aux, we;
    logic [31:0] addr;
    int          dly;
    for (int i = 0; i < 24; i++) begin
      aux  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[31:28] = 4'hF;
      else if (addr[31:28] == 4'hF) addr[31:28] = 4'h0;
      dly = $urandom_range(0, TO + 3);
      run_one(aux, we, addr, $urandom, $urandom, dly, "random");
    end
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_round_robin();
    test_io_write();
    test_io_timeout();
    test_io_edge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
